// File: rtl/register_file.sv
// 32 x 32 register file: two write ports, two registered read ports with
// same-cycle write forwarding, and a per-register pending scoreboard.
module register_file #(
  parameter bit ZERO_R0 = 1'b1,
  parameter int DEPTH   = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  write,
  input  logic [31:0] wr1,
  input  logic [31:0] wr2,
  input  logic [4:0]  wa1,
  input  logic [4:0]  wa2,
  input  logic        re,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  output logic [31:0] rd1,
  output logic [31:0] rd2,
  input  logic        lock,
  input  logic [4:0]  la,
  output logic        busy1,
  output logic        busy2
);

  logic [31:0]      r_regs [DEPTH];
  logic [31:0]      r_rd1;
  logic [31:0]      r_rd2;
  logic [DEPTH-1:0] r_pend;

  logic             w_we1;
  logic             w_we2;
  logic             w_lock;
  logic [31:0]      w_rd1_nxt;
  logic [31:0]      w_rd2_nxt;
  logic [DEPTH-1:0] w_pend_nxt;

  // Writes (and locks) aimed at r0 are squashed up front so r0 stays zero.
  assign w_we1  = write[0] && !(ZERO_R0 && (wa1 == 5'd0));
  assign w_we2  = write[1] && !(ZERO_R0 && (wa2 == 5'd0));
  assign w_lock = lock     && !(ZERO_R0 && (la  == 5'd0));

  always_comb begin
    w_rd1_nxt = r_regs[ra1];
    if (w_we1 && (wa1 == ra1)) w_rd1_nxt = wr1;
    if (w_we2 && (wa2 == ra1)) w_rd1_nxt = wr2;
  end

  always_comb begin
    w_rd2_nxt = r_regs[ra2];
    if (w_we1 && (wa1 == ra2)) w_rd2_nxt = wr1;
    if (w_we2 && (wa2 == ra2)) w_rd2_nxt = wr2;
  end

  // Writeback clears first, then a new lock re-sets the bit.
  always_comb begin
    w_pend_nxt = r_pend;
    if (w_we1)  w_pend_nxt[wa1] = 1'b0;
    if (w_we2)  w_pend_nxt[wa2] = 1'b0;
    if (w_lock) w_pend_nxt[la]  = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_regs[i] <= '0;
    end else begin
      if (w_we1) r_regs[wa1] <= wr1;
      if (w_we2) r_regs[wa2] <= wr2;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd1  <= '0;
      r_rd2  <= '0;
      r_pend <= '0;
    end else begin
      if (re) begin
        r_rd1 <= w_rd1_nxt;
        r_rd2 <= w_rd2_nxt;
      end
      r_pend <= w_pend_nxt;
    end
  end

  assign rd1   = r_rd1;
  assign rd2   = r_rd2;
  assign busy1 = r_pend[ra1];
  assign busy2 = r_pend[ra2];

endmodule

// File: doc/register_file.md
Name: register_file

Overview:
- 32 x 32-bit general register file that consumes the writeback stage's outputs: two write ports driven by write/wr1/wr2/wa1/wa2.
- Two read ports serve the decode/operand-fetch stage.
- Synchronous, registered reads with same-cycle write forwarding.
- A per-register pending scoreboard lets issue logic lock destination registers and detect hazards. Writeback clears the lock.

Parameters:
- ZERO_R0, 1, when 1: r0 reads as 0 and writes to r0 are discarded; when 0: r0 is an ordinary register.
- DEPTH, 32, number of registers; addresses are 5 bits, so DEPTH must be 32.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- write  input  2  write enables: bit0 = port 1, bit1 = port 2.
- wr1  input  32  port 1 write data.
- wr2  input  32  port 2 write data.
- wa1  input  5  port 1 write address.
- wa2  input  5  port 2 write address.
- re  input  1  read enable; when 0, rd1/rd2 hold their values.
- ra1  input  5  read address, port 1.
- ra2  input  5  read address, port 2.
- rd1  output  32  registered read data, port 1.
- rd2  output  32  registered read data, port 2.
- lock  input  1  set the pending bit for register la.
- la  input  5  register to lock.
- busy1  output  1  combinational: pending bit of ra1.
- busy2  output  1  combinational: pending bit of ra2.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values:
  - All 32 registers = 0.
  - rd1 = rd2 = 0.
  - All pending bits = 0, so busy1 = busy2 = 0.
  - rst asserted mid-operation aborts any write in that cycle.
- Writes, at posedge:
  - If write[0]: reg[wa1] <= wr1.
  - If write[1]: reg[wa2] <= wr2.
  - write[1] without write[0] is legal.
  - wr2/wa2 are ignored when write[1] = 0, even if stale.
- Write conflict: when write = 2'b11 and wa1 == wa2, port 2 wins (reg gets wr2).
- r0 with ZERO_R0 = 1: any write to address 0 is dropped, reads of address 0 return 0, and the pending bit of r0 never sets.
- Reads, 1-cycle latency: at posedge with re = 1, rdN <= value of reg[raN] as seen after this cycle's writes.
- Read forwarding: if raN matches an enabled write address in the same cycle, rdN gets the incoming write data. Port 2 has priority if both ports match.
- re = 0: rd1/rd2 hold their values; writes still occur.
- Scoreboard, at posedge:
  - Each pending bit clears when an enabled write port targets its register.
  - lock = 1 sets pending[la].
  - Lock and clear of the same register in the same cycle: lock wins (a new producer has been issued), so the bit stays 1.
  - Locking an already-pending register: the bit stays 1; there is no count.
- busyN = pending[raN] from the current state (pre-edge). No forwarding into busy: a register being written this cycle still shows busy until the next cycle.
- No other state machine; all sequential state is the array, the rd registers and the pending vector.

Test Plan:
- Reset then read: assert rst asynchronously between edges; rd1/rd2 = 0 immediately. Read ra1 = 5, ra2 = 31 -> rd1 = rd2 = 0 one cycle later.
- Single and dual write:
  - write = 01, wa1 = 3, wr1 = 32'hDEADBEEF -> next-cycle read ra1 = 3 gives 32'hDEADBEEF.
  - write = 11, wa1 = 4/wr1 = 1, wa2 = 9/wr2 = 2 -> reads give 1 and 2.
- Conflict and r0:
  - write = 11, wa1 = wa2 = 7, wr1 = 32'h11, wr2 = 32'h22 -> reg7 = 32'h22.
  - write = 01, wa1 = 0, wr1 = 32'hFF -> read r0 = 0.
- Forwarding: same cycle write = 01, wa1 = 12, wr1 = 32'hA5A5A5A5 with re = 1, ra1 = ra2 = 12 -> rd1 = rd2 = 32'hA5A5A5A5 at that edge.
- Scoreboard:
  - lock = 1, la = 6 -> busy1 = 1 when ra1 = 6.
  - write = 01, wa1 = 6 -> busy1 still 1 in the write cycle, 0 the next cycle.
  - Simultaneous lock la = 6 and write wa1 = 6 -> busy stays 1.
- Hold and mid-operation reset:
  - re = 0 while writing ra1's register -> rd1 unchanged.
  - rst pulse during write = 11 -> array and pending all 0, write lost.
